// File: rtl/fetch_pkg.sv
// Shared constants and state type for the instruction fetch unit.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction + PC buffer; captures the memory output when decode stalls.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc_in,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        valid
);

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            inst_d  = inst_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign inst  = inst_q;
    assign pc    = pc_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end over a one-cycle synchronous program memory.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky fetch_fault instead of being aligned.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [31:0] PC,
    output logic        flush,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic        fetch_fault
);

    if (RESET_PC >= MEM_BYTES) begin : g_reset_pc_range
        $error("fetch_unit: RESET_PC lies outside program memory");
    end

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  resp_pc_q, resp_pc_d;
    logic [31:0]  target_aligned;
    logic         skid_load, skid_clear, skid_valid, use_skid;
    logic [31:0]  skid_inst, skid_pc;
    logic         fault_active;

    assign target_aligned = redirect_target & ~32'h3;

    // Redirect outranks stall in every state and always restarts from BOOT.
    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        state_d    = state_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (redirect_valid) begin
            pc_d       = target_aligned;
            state_d    = BOOT;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                BOOT: begin
                    pc_d      = pc_q + 32'd4;
                    resp_pc_d = pc_q;
                    state_d   = RUN;
                end
                RUN: begin
                    resp_pc_d = pc_q;
                    if (stall) begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_d       = pc_q + 32'd4;
                        resp_pc_d  = pc_q;
                        state_d    = RUN;
                        skid_clear = 1'b1;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            resp_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk     (Clock),
        .rst     (Reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .inst_in (instruction),
        .pc_in   (resp_pc_q),
        .inst    (skid_inst),
        .pc      (skid_pc),
        .valid   (skid_valid)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;

    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) fault_d = |redirect_target[1:0];
    end

    always_ff @(posedge Clock) begin
        if (Reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end

    assign fault_active = fault_q;
`else
    assign fault_active = 1'b0;
`endif

    assign PC          = pc_q;
    assign flush       = Reset | redirect_valid;
    assign valid_out   = (state_q != BOOT) && !flush && !fault_active;
    assign use_skid    = (state_q == HOLD) && skid_valid;
    assign fetch_fault = fault_active & ~Reset;

    always_comb begin
        inst_out = NOP_INSTR;
        pc_out   = '0;
        if (valid_out) begin
            inst_out = use_skid ? skid_inst : instruction;
            pc_out   = use_skid ? skid_pc   : resp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program-memory model, stream-level reference model, directed vectors.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] instruction;
    logic [31:0] PC, inst_out, pc_out;
    logic        flush, valid_out, fetch_fault;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [64];

    always #5 Clock = ~Clock;

    fetch_unit #(.RESET_PC(RPC), .MEM_BYTES(256)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .PC              (PC),
        .flush           (flush),
        .instruction     (instruction),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_out        (inst_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out),
        .fetch_fault     (fetch_fault)
    );

    // Program memory: registered read, flush substitutes a NOP
    always @(posedge Clock) instruction <= flush ? NOP_INSTR : mem[PC[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: next address to deliver, invalid cycles left before delivery, fault flag
    bit          m_ok = 1'b0;
    logic [31:0] m_cur = '0;
    int          m_gap = 0;
    bit          m_fault = 1'b0;
    logic        m_ev;

    always @(posedge Clock) begin
        if (Reset) begin
            m_ok    = 1'b1;
            m_cur   = RPC;
            m_gap   = 1;
            m_fault = 1'b0;
        end else if (redirect_valid) begin
            m_cur = {redirect_target[31:2], 2'b00};
            m_gap = 1;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_fault = (redirect_target[1:0] != 2'b00);
`endif
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end else if (!stall) begin
            m_cur = m_cur + 32'd4;
        end
    end

    always @(negedge Clock) begin
        if (m_ok) begin
            m_ev = !Reset && !redirect_valid && (m_gap == 0) && !m_fault;
            chk("model flush", {31'b0, flush}, {31'b0, Reset | redirect_valid});
            chk("model valid_out", {31'b0, valid_out}, {31'b0, m_ev});
            chk("model fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault && !Reset});
            if (m_ev) begin
                chk("model pc_out", pc_out, m_cur);
                chk("model inst_out", inst_out, mem[m_cur[7:2]]);
            end
            if (!Reset && !redirect_valid)
                chk("model PC", PC, (m_gap != 0) ? m_cur : m_cur + 32'd4);
        end
    end

    task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] t);
        @(posedge Clock);
        #1;
        Reset           = r;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = t;
        @(negedge Clock);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | (i * 4);

        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("reset valid_out", {31'b0, valid_out}, 32'd0);
        chk("reset inst_out", inst_out, 32'h0000_0013);
        chk("reset pc_out", pc_out, 32'd0);
        chk("reset flush", {31'b0, flush}, 32'd1);
        chk("reset fetch_fault", {31'b0, fetch_fault}, 32'd0);
        chk("reset PC", PC, 32'd0);

        drive(0, 0, 0, 0);                                  // c0 BOOT
        chk("c0 valid_out", {31'b0, valid_out}, 32'd0);
        chk("c0 PC", PC, 32'd0);
        drive(0, 0, 0, 0);                                  // c1
        chk("c1 valid_out", {31'b0, valid_out}, 32'd1);
        chk("c1 pc_out", pc_out, 32'd0);
        chk("c1 inst_out", inst_out, 32'hC0DE_0000);
        chk("c1 PC", PC, 32'd4);
        drive(0, 0, 0, 0);                                  // c2
        chk("c2 PC", PC, 32'd8);

        for (int i = 0; i < 3; i++) begin                   // c3..c5 stall
            drive(0, 1, 0, 0);
            chk("stall pc_out", pc_out, 32'd8);
            chk("stall PC", PC, 32'd12);
        end
        drive(0, 0, 0, 0);                                  // c6 release
        chk("c6 pc_out", pc_out, 32'd8);
        chk("c6 inst_out", inst_out, 32'hC0DE_0008);
        drive(0, 0, 0, 0);                                  // c7
        chk("c7 pc_out", pc_out, 32'd12);
        chk("c7 PC", PC, 32'd16);

        drive(0, 0, 1, 32'h40);                             // c8 redirect while pc_out=0x10
        chk("c8 flush", {31'b0, flush}, 32'd1);
        chk("c8 valid_out", {31'b0, valid_out}, 32'd0);
        drive(0, 0, 0, 0);                                  // c9
        chk("c9 valid_out", {31'b0, valid_out}, 32'd0);
        chk("c9 PC", PC, 32'h40);
        drive(0, 0, 0, 0);                                  // c10
        chk("c10 pc_out", pc_out, 32'h40);
        chk("c10 inst_out", inst_out, 32'hC0DE_0040);

        drive(0, 1, 0, 0);                                  // c11 RUN stall
        chk("c11 pc_out", pc_out, 32'h44);
        drive(0, 1, 1, 32'h80);                             // c12 HOLD + redirect
        chk("c12 valid_out", {31'b0, valid_out}, 32'd0);
        drive(0, 0, 0, 0);                                  // c13
        drive(0, 0, 0, 0);                                  // c14
        chk("c14 pc_out", pc_out, 32'h80);
        chk("c14 inst_out", inst_out, 32'hC0DE_0080);

        drive(0, 1, 0, 0);                                  // c15 RUN stall
        drive(1, 1, 0, 0);                                  // c16 Reset during HOLD
        chk("c16 valid_out", {31'b0, valid_out}, 32'd0);
        drive(0, 0, 0, 0);                                  // c17
        chk("c17 valid_out", {31'b0, valid_out}, 32'd0);
        chk("c17 PC", PC, RPC);
        chk("c17 inst_out", inst_out, 32'h0000_0013);
        drive(0, 0, 0, 0);                                  // c18
        chk("c18 pc_out", pc_out, 32'd0);

        drive(0, 0, 1, 32'h20);                             // c19
        drive(0, 0, 1, 32'h30);                             // c20 latest target wins
        drive(0, 0, 0, 0);                                  // c21
        chk("c21 PC", PC, 32'h30);
        drive(0, 0, 0, 0);                                  // c22
        chk("c22 pc_out", pc_out, 32'h30);
        chk("c22 inst_out", inst_out, 32'hC0DE_0030);

        drive(0, 0, 1, 32'hFFFF_FFFC);                      // c23 wrap test
        drive(0, 0, 0, 0);                                  // c24
        drive(0, 0, 0, 0);                                  // c25
        chk("c25 pc_out", pc_out, 32'hFFFF_FFFC);
        chk("c25 inst_out", inst_out, 32'hC0DE_00FC);
        chk("c25 PC", PC, 32'd0);
        drive(0, 0, 0, 0);                                  // c26
        chk("c26 pc_out", pc_out, 32'd0);

`ifdef FETCH_MISALIGN_TRAP_EN
        drive(0, 0, 1, 32'h42);                             // c27 misaligned
        for (int i = 0; i < 3; i++) begin                   // c28..c30
            drive(0, 0, 0, 0);
            chk("fault fetch_fault", {31'b0, fetch_fault}, 32'd1);
            chk("fault valid_out", {31'b0, valid_out}, 32'd0);
        end
        drive(0, 0, 1, 32'h44);                             // c31 aligned redirect
        drive(0, 0, 0, 0);                                  // c32
        chk("c32 fetch_fault", {31'b0, fetch_fault}, 32'd0);
        drive(0, 0, 0, 0);                                  // c33
        chk("c33 valid_out", {31'b0, valid_out}, 32'd1);
        chk("c33 pc_out", pc_out, 32'h44);
`else
        drive(0, 0, 1, 32'h0A);                             // c27 misaligned, forced aligned
        drive(0, 0, 0, 0);                                  // c28
        chk("c28 PC", PC, 32'h08);
        chk("c28 fetch_fault", {31'b0, fetch_fault}, 32'd0);
        drive(0, 0, 0, 0);                                  // c29
        chk("c29 pc_out", pc_out, 32'h08);
        chk("c29 inst_out", inst_out, 32'hC0DE_0008);
`endif

        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
